// File: rtl/uart_pkg.sv
// uart_pkg: FSM encodings, frame constants and baud helper shared by the UART TX and RX paths
package uart_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty/level; writes while full are dropped
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] level_q, level_d;
  logic full_q, empty_q, push, pop;
  assign push    = wr_en && !full_q;
  assign pop     = rd_en && !empty_q;
  assign level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign level   = level_q;
  // pointers and occupancy flags, all derived from the same next level so they never disagree
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_q  <= level_d;
      full_q   <= level_d == (AW+1)'(DEPTH);
      empty_q  <= level_d == '0;
    end
  end
  // storage array, no reset needed since empty gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter draining an internal byte FIFO back-to-back onto tx
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 50,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        busy,
  output logic                        done,
  output logic                        tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, head;
  logic tx_q, tx_d, done_q, done_d, pop, last;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );
  assign last = cnt_q == CNT_MAX;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign tx   = tx_q;
  // frame sequencer: the stop-bit end pops the next byte directly so frames run gap-free
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        shift_d = head;
        tx_d    = 1'b0;
        state_d = START;
      end
      START: if (last) begin
        tx_d    = shift_q[0];
        bit_d   = '0;
        state_d = DATA;
      end
      DATA: if (last) begin
        if (bit_q == 3'(DATA_BITS - 1)) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
          bit_d   = bit_q + 1'b1;
        end
      end
      default: if (last) begin
        done_d  = 1'b1;
        pop     = !empty;
        shift_d = empty ? shift_q : head;
        tx_d    = empty;
        state_d = empty ? IDLE : START;
      end
    endcase
  end
  // state registers; reset parks the line high and abandons any frame in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a line monitor decoding frames from the main instance
module tb_uart_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en [3];
  logic [7:0] wr_data [3];
  logic full_v [3], empty_v [3], busy_v [3], done_v [3], tx_v [3];
  logic [2:0] lvl [3];
  int n_chk = 0, n_fail = 0, cyc = 0, rx_ferr = 0;
  logic [7:0] rxq [$];
  int starts [$];
  int done_q [$];
  int lvl_max = 0;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic [2:0] lvl;
    logic       full;
    logic       empty;
  } vec_t;
  vec_t vecs [7];

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en[0]), .wr_data(wr_data[0]), .full(full_v[0]),
    .empty(empty_v[0]), .level(lvl[0]), .busy(busy_v[0]), .done(done_v[0]), .tx(tx_v[0]));
  uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) u_c2 (
    .clk(clk), .reset(reset), .wr_en(wr_en[1]), .wr_data(wr_data[1]), .full(full_v[1]),
    .empty(empty_v[1]), .level(lvl[1]), .busy(busy_v[1]), .done(done_v[1]), .tx(tx_v[1]));
  uart_tx #(.CLKS_PER_BIT(433), .FIFO_DEPTH(4)) u_c433 (
    .clk(clk), .reset(reset), .wr_en(wr_en[2]), .wr_data(wr_data[2]), .full(full_v[2]),
    .empty(empty_v[2]), .level(lvl[2]), .busy(busy_v[2]), .done(done_v[2]), .tx(tx_v[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (done_v[0] === 1'b1) done_q.push_back(cyc);
      if (int'(lvl[0]) > lvl_max) lvl_max = int'(lvl[0]);
    end
  end

  initial begin
    logic [7:0] b;
    int st;
    bit ab, fe;
    forever begin
      @(posedge clk); #1;
      if (tx_v[0] === 1'b0 && busy_v[0] === 1'b1) begin
        st = cyc; ab = 0; fe = 0; b = '0;
        for (int i = 1; i < 40; i++) begin
          @(posedge clk); #1;
          if (busy_v[0] !== 1'b1) ab = 1;
          if (i % 4 == 2) begin
            if (i / 4 == 0) fe = fe | (tx_v[0] !== 1'b0);
            else if (i / 4 == 9) fe = fe | (tx_v[0] !== 1'b1);
            else b[i/4-1] = tx_v[0];
          end
        end
        if (!ab) begin
          rxq.push_back(b);
          starts.push_back(st);
          if (fe) rx_ferr++;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) wr_en[i] = 1'b0;
    step(1);
    chk("rst_tx", tx_v[0], 1);
    chk("rst_busy", busy_v[0], 0);
    chk("rst_done", done_v[0], 0);
    chk("rst_full", full_v[0], 0);
    chk("rst_empty", empty_v[0], 1);
    chk("rst_level", lvl[0], 0);
    step(1);
    reset = 1'b0;
    rxq.delete();
    starts.delete();
    done_q.delete();
    lvl_max = 0;
  endtask

  task automatic push(input int sel, input logic [7:0] d);
    wr_en[sel] = 1'b1;
    wr_data[sel] = d;
    step(1);
    wr_en[sel] = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int w = 0;
    while (rxq.size() < n && w < budget) begin step(1); w++; end
    chk("rx_count", rxq.size(), n);
  endtask

  task automatic chk_rx(input int i, input logic [7:0] exp);
    chk($sformatf("rx_byte%0d", i), (i < rxq.size()) ? 32'(rxq[i]) : 32'hFFFF_FFFF, 32'(exp));
  endtask

  // walks one isolated frame cycle by cycle from the sample after the write edge
  task automatic check_frame(input int sel, input int cpb, input logic [7:0] d, input int exp_wait);
    logic [9:0] fr;
    int w, e;
    fr = {1'b1, d, 1'b0};
    w = 0;
    while (tx_v[sel] !== 1'b0 && w < 20) begin step(1); w++; end
    chk($sformatf("fall_wait_c%0d", cpb), w, exp_wait);
    for (int k = 0; k < 10; k++) begin
      e = 0;
      for (int c = 0; c < cpb; c++) begin
        if (tx_v[sel] !== fr[k] || busy_v[sel] !== 1'b1 || ((k | c) != 0 && done_v[sel] !== 1'b0)) e++;
        step(1);
      end
      chk($sformatf("c%0d_bit%0d_errs", cpb, k), e, 0);
    end
    chk($sformatf("c%0d_frame_done", cpb), done_v[sel], 1);
    chk($sformatf("c%0d_frame_idle", cpb), busy_v[sel], 0);
    chk($sformatf("c%0d_frame_tx", cpb), tx_v[sel], 1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin wr_en[i] = 1'b0; wr_data[i] = '0; end
    vecs[0] = '{1'b1, 8'h11, 3'd1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h12, 3'd1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h13, 3'd2, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h14, 3'd3, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h15, 3'd4, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h16, 3'd4, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 3'd4, 1'b1, 1'b0};

    // single frame 0xA5
    do_reset();
    push(0, 8'hA5);
    chk("t1_level", lvl[0], 1);
    chk("t1_empty", empty_v[0], 0);
    chk("t1_tx_before", tx_v[0], 1);
    check_frame(0, 4, 8'hA5, 1);
    chk("t1_empty_after", empty_v[0], 1);
    step(1);
    chk("t1_done_cleared", done_v[0], 0);
    chk("t1_done_count", done_q.size(), 1);

    // three back-to-back frames
    do_reset();
    wr_en[0] = 1'b1;
    wr_data[0] = 8'h00; step(1);
    wr_data[0] = 8'hFF; step(1);
    wr_data[0] = 8'h55; step(1);
    wr_en[0] = 1'b0;
    wait_rx(3, 200);
    step(5);
    chk_rx(0, 8'h00); chk_rx(1, 8'hFF); chk_rx(2, 8'h55);
    chk("t2_gap1", (starts.size() > 1) ? starts[1] - starts[0] : -1, 40);
    chk("t2_gap2", (starts.size() > 2) ? starts[2] - starts[0] : -1, 80);
    chk("t2_done_count", done_q.size(), 3);
    chk("t2_span", (done_q.size() > 2 && starts.size() > 0) ? done_q[2] - starts[0] : -1, 120);
    chk("t2_ferr", rx_ferr, 0);

    // FIFO fill with one overflow write, table driven
    do_reset();
    for (int i = 0; i < 7; i++) begin
      wr_en[0] = vecs[i].wr;
      wr_data[0] = vecs[i].d;
      step(1);
      chk($sformatf("t3_v%0d_level", i), lvl[0], vecs[i].lvl);
      chk($sformatf("t3_v%0d_full", i), full_v[0], vecs[i].full);
      chk($sformatf("t3_v%0d_empty", i), empty_v[0], vecs[i].empty);
    end
    wr_en[0] = 1'b0;
    wait_rx(5, 260);
    step(60);
    chk("t3_rx_total", rxq.size(), 5);
    for (int i = 0; i < 5; i++) chk_rx(i, 8'h11 + 8'(i));
    chk("t3_lvl_max", lvl_max, 4);
    chk("t3_span", (starts.size() > 4) ? starts[4] - starts[0] : -1, 160);
    chk("t3_idle", busy_v[0], 0);
    chk("t3_empty", empty_v[0], 1);
    chk("t3_ferr", rx_ferr, 0);

    // write colliding with pop while full, then while not full
    do_reset();
    wr_en[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin wr_data[0] = 8'hA1 + 8'(i); step(1); end
    wr_en[0] = 1'b0;
    chk("t4_full_level", lvl[0], 4);
    step(36);
    chk("t4_pre_full", full_v[0], 1);
    chk("t4_pre_done", done_v[0], 0);
    wr_en[0] = 1'b1; wr_data[0] = 8'h99;
    step(1);
    wr_en[0] = 1'b0;
    chk("t4_drop_level", lvl[0], 3);
    chk("t4_drop_full", full_v[0], 0);
    chk("t4_drop_done", done_v[0], 1);
    step(39);
    chk("t4_pre2_level", lvl[0], 3);
    wr_en[0] = 1'b1; wr_data[0] = 8'h77;
    step(1);
    wr_en[0] = 1'b0;
    chk("t4_swap_level", lvl[0], 3);
    chk("t4_swap_done", done_v[0], 1);
    wait_rx(6, 300);
    for (int i = 0; i < 5; i++) chk_rx(i, 8'hA1 + 8'(i));
    chk_rx(5, 8'h77);
    chk("t4_ferr", rx_ferr, 0);

    // reset in the middle of data bit 3
    do_reset();
    push(0, 8'hC3);
    wr_en[0] = 1'b1;
    wr_data[0] = 8'h01; step(1);
    wr_data[0] = 8'h02; step(1);
    wr_en[0] = 1'b0;
    step(15);
    chk("t5_level_pre", lvl[0], 2);
    chk("t5_busy_pre", busy_v[0], 1);
    chk("t5_bit3", tx_v[0], 0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t5_tx", tx_v[0], 1);
    chk("t5_level", lvl[0], 0);
    chk("t5_busy", busy_v[0], 0);
    chk("t5_done", done_v[0], 0);
    chk("t5_empty", empty_v[0], 1);
    step(60);
    chk("t5_no_done", done_q.size(), 0);
    chk("t5_no_rx", rxq.size(), 0);
    push(0, 8'h7E);
    wait_rx(1, 100);
    chk_rx(0, 8'h7E);
    chk("t5_ferr", rx_ferr, 0);

    // bit-period extremes on the other instances
    step(10);
    push(1, 8'h55);
    check_frame(1, 2, 8'h55, 1);
    push(2, 8'h55);
    check_frame(2, 433, 8'h55, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
